// File: rtl/alien_formation.sv
// Alien formation mover: sweeps the 5x10 grid across the screen,
// drops a row at each edge and halts on landing or defeat.
module alien_formation #(
  parameter int BasePeriod    = 5000000,
  parameter int FastPeriod    = 1250000,
  parameter int FastThreshold = 10,
  parameter int StepX         = 10,
  parameter int StepY         = 10,
  parameter int StartCol      = 20,
  parameter int StartRow      = 40,
  parameter int LandRow       = 440,
  parameter int ScreenWidth   = 640
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Enable,
  input  logic [49:0] Aliens_Grid,
  input  logic        Aliens_Defeated,
  output logic [8:0]  Aliens_Row,
  output logic [9:0]  Aliens_Col,
  output logic        Step_Tick,
  output logic        Aliens_Landed,
  output logic        Direction
);

  typedef enum logic [1:0] {
    MOVE_RIGHT = 2'd0,
    MOVE_LEFT  = 2'd1,
    HALTED     = 2'd2
  } state_t;

  localparam logic [22:0] BaseM1 = 23'(BasePeriod - 1);
  localparam logic [22:0] FastM1 = 23'(FastPeriod - 1);

  state_t      r_state;
  logic [22:0] r_cnt;
  logic [8:0]  r_row;
  logic [9:0]  r_col;
  logic        r_tick;
  logic        r_landed;
  logic        r_dir;

  logic [9:0]  w_col_any;
  logic [4:0]  w_row_any;
  logic [5:0]  w_count;
  logic [3:0]  w_jmin;
  logic [3:0]  w_jmax;
  logic [2:0]  w_imax;

  always_comb begin
    w_col_any = '0;
    w_row_any = '0;
    w_count   = '0;
    for (int i = 0; i < 5; i++) begin
      for (int j = 0; j < 10; j++) begin
        if (Aliens_Grid[i*10+j]) begin
          w_col_any[j] = 1'b1;
          w_row_any[i] = 1'b1;
          w_count      = w_count + 6'd1;
        end
      end
    end
    w_jmin = '0;
    for (int j = 9; j >= 0; j--)
      if (w_col_any[j]) w_jmin = 4'(j);
    w_jmax = '0;
    for (int j = 0; j < 10; j++)
      if (w_col_any[j]) w_jmax = 4'(j);
    w_imax = '0;
    for (int i = 0; i < 5; i++)
      if (w_row_any[i]) w_imax = 3'(i);
  end

  logic [11:0] w_xmax;
  logic [11:0] w_xmin;
  logic [11:0] w_ybot;
  logic        w_drop_r;
  logic        w_drop_l;
  logic        w_land;
  logic        w_kill;
  logic        w_due;
  logic [22:0] w_lim;
  logic [9:0]  w_col_dec;

  assign w_xmin = {2'b0, r_col} + 12'd40 * {8'b0, w_jmin};
  assign w_xmax = {2'b0, r_col} + 12'd40 * {8'b0, w_jmax}
                + 12'(30 + StepX);
  assign w_ybot = {3'b0, r_row} + 12'd30 * {9'b0, w_imax} + 12'd20;

  assign w_drop_r = w_xmax > 12'(ScreenWidth - 1);
  assign w_drop_l = w_xmin < 12'(StepX);
  assign w_kill   = Aliens_Defeated || (Aliens_Grid == '0);
  assign w_land   = w_ybot >= 12'(LandRow);
  assign w_lim    = (w_count <= 6'(FastThreshold)) ? FastM1 : BaseM1;
  assign w_due    = r_cnt >= w_lim;

  // Saturate so a left step with jmin > 0 can never wrap below 0
  assign w_col_dec = (r_col >= 10'(StepX)) ? r_col - 10'(StepX) : '0;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state  <= MOVE_RIGHT;
      r_cnt    <= '0;
      r_row    <= 9'(StartRow);
      r_col    <= 10'(StartCol);
      r_tick   <= 1'b0;
      r_landed <= 1'b0;
      r_dir    <= 1'b1;
    end else begin
      r_tick <= 1'b0;
      case (r_state)
        HALTED: ;
        default: begin
          if (w_kill) begin
            r_state <= HALTED;
            r_cnt   <= '0;
          end else if (Enable && w_land) begin
            r_landed <= 1'b1;
            r_state  <= HALTED;
            r_cnt    <= '0;
          end else if (Enable) begin
            if (w_due) begin
              r_cnt  <= '0;
              r_tick <= 1'b1;
              if (r_state == MOVE_RIGHT) begin
                if (w_drop_r) begin
                  r_row   <= r_row + 9'(StepY);
                  r_state <= MOVE_LEFT;
                  r_dir   <= 1'b0;
                end else begin
                  r_col <= r_col + 10'(StepX);
                end
              end else begin
                if (w_drop_l) begin
                  r_row   <= r_row + 9'(StepY);
                  r_state <= MOVE_RIGHT;
                  r_dir   <= 1'b1;
                end else begin
                  r_col <= w_col_dec;
                end
              end
            end else begin
              r_cnt <= r_cnt + 23'd1;
            end
          end
        end
      endcase
    end
  end

  assign Aliens_Row    = r_row;
  assign Aliens_Col    = r_col;
  assign Step_Tick     = r_tick;
  assign Aliens_Landed = r_landed;
  assign Direction     = r_dir;

endmodule

// File: tb/tb_alien_formation.sv
// Bench for alien_formation: behavioural model checked every cycle,
// directed scenarios with literal expectations, then random play.
module tb_alien_formation;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Enable = 1'b0;
  logic [49:0] Aliens_Grid = '1;
  logic        Aliens_Defeated = 1'b0;
  logic [8:0]  Aliens_Row;
  logic [9:0]  Aliens_Col;
  logic        Step_Tick;
  logic        Aliens_Landed;
  logic        Direction;

  alien_formation #(
    .BasePeriod(4),
    .FastPeriod(2)
  ) dut (
    .Clk(Clk),
    .Reset(Reset),
    .Enable(Enable),
    .Aliens_Grid(Aliens_Grid),
    .Aliens_Defeated(Aliens_Defeated),
    .Aliens_Row(Aliens_Row),
    .Aliens_Col(Aliens_Col),
    .Step_Tick(Step_Tick),
    .Aliens_Landed(Aliens_Landed),
    .Direction(Direction)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  int m_row, m_col, m_right, m_elapsed;
  int m_tick, m_landed, m_halted;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               name, act, exp, $time);
    end
  endtask

  // Formation geometry from the alive mask
  task automatic grid_info(input logic [49:0] g, output int pop,
                           output int jmin, output int jmax,
                           output int imax);
    pop = 0; jmin = 99; jmax = -1; imax = -1;
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 10; j++)
        if (g[i*10+j]) begin
          pop++;
          if (j < jmin) jmin = j;
          if (j > jmax) jmax = j;
          if (i > imax) imax = i;
        end
  endtask

  task automatic model_step();
    int pop, jmin, jmax, imax, period;
    grid_info(Aliens_Grid, pop, jmin, jmax, imax);
    period = (pop <= 10) ? 2 : 4;
    m_tick = 0;
    if (Reset) begin
      m_row = 40; m_col = 20; m_right = 1; m_elapsed = 0;
      m_landed = 0; m_halted = 0;
    end else if (!m_halted) begin
      if (Aliens_Defeated || pop == 0) begin
        m_halted = 1;
      end else if (Enable) begin
        if (m_row + 30 * imax + 20 >= 440) begin
          m_landed = 1;
          m_halted = 1;
        end else begin
          m_elapsed++;
          if (m_elapsed >= period) begin
            m_elapsed = 0;
            m_tick = 1;
            if (m_right) begin
              if (m_col + 40 * jmax + 30 + 10 > 639) begin
                m_row += 10; m_right = 0;
              end else m_col += 10;
            end else begin
              if (m_col + 40 * jmin < 10) begin
                m_row += 10; m_right = 1;
              end else m_col = (m_col >= 10) ? m_col - 10 : 0;
            end
          end
        end
      end
    end
  endtask

  task automatic cycle();
    @(posedge Clk);
    model_step();
    #1;
    chk("row", int'(Aliens_Row), m_row);
    chk("col", int'(Aliens_Col), m_col);
    chk("tick", int'(Step_Tick), m_tick);
    chk("landed", int'(Aliens_Landed), m_landed);
    chk("dir", int'(Direction), m_right);
  endtask

  task automatic run_steps(input int n, output int cyc);
    int k = 0;
    cyc = 0;
    while (k < n && cyc < 200 * n) begin
      cycle();
      cyc++;
      if (Step_Tick) k++;
    end
    if (k < n) chk("step_timeout", k, n);
  endtask

  task automatic do_reset(input logic [49:0] g);
    Aliens_Grid = g;
    Aliens_Defeated = 1'b0;
    Reset = 1'b1;
    cycle();
    Reset = 1'b0;
  endtask

  initial begin
    int c, t, snap_r, snap_c;
    logic [49:0] g;

    // Reset state and step cadence with full grid
    Enable = 1'b1;
    do_reset('1);
    chk("rst_row", int'(Aliens_Row), 40);
    chk("rst_col", int'(Aliens_Col), 20);
    chk("rst_dir", int'(Direction), 1);
    chk("rst_land", int'(Aliens_Landed), 0);
    run_steps(1, c);
    chk("period4_first", c, 4);
    chk("col_after1", int'(Aliens_Col), 30);
    run_steps(1, c);
    chk("period4_next", c, 4);
    run_steps(20, c);
    chk("col_after22", int'(Aliens_Col), 240);
    run_steps(1, c);
    chk("drop1_row", int'(Aliens_Row), 50);
    chk("drop1_col", int'(Aliens_Col), 240);
    chk("drop1_dir", int'(Direction), 0);
    run_steps(24, c);
    chk("left24_col", int'(Aliens_Col), 0);
    run_steps(1, c);
    chk("drop2_row", int'(Aliens_Row), 60);
    chk("drop2_col", int'(Aliens_Col), 0);
    chk("drop2_dir", int'(Direction), 1);

    // Columns 8-9 cleared: jmax = 7
    g = '1;
    for (int i = 0; i < 5; i++) begin
      g[i*10+8] = 1'b0;
      g[i*10+9] = 1'b0;
    end
    do_reset(g);
    run_steps(30, c);
    chk("jmax7_col", int'(Aliens_Col), 320);
    chk("jmax7_dir", int'(Direction), 1);
    run_steps(1, c);
    chk("jmax7_drop_row", int'(Aliens_Row), 50);
    chk("jmax7_drop_col", int'(Aliens_Col), 320);

    // Fast period switch mid-count
    do_reset('1);
    run_steps(1, c);
    cycle();
    cycle();
    Aliens_Grid = 50'h3FF;
    run_steps(1, c);
    chk("fast_switch", c, 1);
    run_steps(1, c);
    chk("fast_period", c, 2);
    run_steps(1, c);
    chk("fast_period2", c, 2);

    // Landing with imax = 4
    do_reset('1);
    c = 0;
    while (!m_landed && c < 6000) begin
      cycle();
      c++;
    end
    chk("land_flag", int'(Aliens_Landed), 1);
    chk("land_row", int'(Aliens_Row), 300);
    t = 0;
    for (int k = 0; k < 20; k++) begin
      cycle();
      t += int'(Step_Tick);
    end
    chk("land_noticks", t, 0);
    do_reset('1);
    chk("land_rst_row", int'(Aliens_Row), 40);
    chk("land_rst_col", int'(Aliens_Col), 20);
    chk("land_rst_flag", int'(Aliens_Landed), 0);

    // Pause then defeat
    run_steps(3, c);
    snap_r = m_row;
    snap_c = m_col;
    Enable = 1'b0;
    t = 0;
    for (int k = 0; k < 10; k++) begin
      cycle();
      t += int'(Step_Tick);
    end
    chk("pause_ticks", t, 0);
    chk("pause_row", int'(Aliens_Row), snap_r);
    chk("pause_col", int'(Aliens_Col), snap_c);
    Enable = 1'b1;
    cycle();
    Aliens_Defeated = 1'b1;
    cycle();
    Aliens_Defeated = 1'b0;
    t = 0;
    for (int k = 0; k < 20; k++) begin
      cycle();
      t += int'(Step_Tick);
    end
    chk("defeat_ticks", t, 0);
    chk("defeat_landed", int'(Aliens_Landed), 0);

    // Random play
    do_reset('1);
    for (int k = 0; k < 6000; k++) begin
      Enable = ($urandom_range(0, 9) != 0);
      Aliens_Defeated = ($urandom_range(0, 999) == 0);
      if ($urandom_range(0, 19) == 0)
        Aliens_Grid[$urandom_range(0, 49)] = 1'b0;
      Reset = ($urandom_range(0, 299) == 0);
      if (Reset)
        Aliens_Grid = {$urandom(), $urandom()} | 50'h1;
      cycle();
    end
    Reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/alien_formation.md
ALIEN_FORMATION -- requirements
Module: alien_formation

Interface
REQ-001 Parameters (name, default, meaning):
- BasePeriod, 5000000: clocks per step when many aliens are alive.
- FastPeriod, 1250000: clocks per step when few aliens are alive.
- FastThreshold, 10: alive count at or below which FastPeriod applies.
- StepX, 10: horizontal pixels per step.
- StepY, 10: vertical pixels per drop.
- StartCol, 20: reset formation x.
- StartRow, 40: reset formation y.
- LandRow, 440: y at which aliens have landed.
- ScreenWidth, 640: visible width in pixels.

REQ-002 Ports (name, direction, width, meaning):
- Clk, in, 1: single clock.
- Reset, in, 1: synchronous, active-high reset.
- Enable, in, 1: game running; low pauses the block.
- Aliens_Grid, in, 50: alive mask from the bullet stage; bit i*10+j is row i (0..4), column j (0..9).
- Aliens_Defeated, in, 1: high when all aliens are destroyed.
- Aliens_Row, out, 9: formation origin y.
- Aliens_Col, out, 10: formation origin x.
- Step_Tick, out, 1: one-cycle pulse on each formation move.
- Aliens_Landed, out, 1: sticky flag; aliens reached LandRow.
- Direction, out, 1: 1 = moving right, 0 = moving left.

Function
REQ-003 Geometry:
- Alien at (i,j) occupies x = Aliens_Col+40*j to +30.
- Alien at (i,j) occupies y = Aliens_Row+30*i to +20.
REQ-004 jmin/jmax SHALL be the lowest/highest column index with any set bit; imax SHALL be the highest row index with any set bit. All three are combinational from the current Aliens_Grid.
REQ-005 The alive count SHALL be the popcount of Aliens_Grid (0..50). The active period SHALL be FastPeriod when count <= FastThreshold, else BasePeriod.
REQ-006 The tick counter SHALL be 23 bits wide.
- It increments each cycle while state is MOVE_RIGHT or MOVE_LEFT and Enable = 1.
- When counter >= active period - 1, it clears to 0 and a step occurs that cycle.
- A period switch mid-count SHALL cause at most one immediate step.
REQ-007 Step_Tick SHALL be registered: high for exactly the one cycle in which Aliens_Row/Aliens_Col show the new position.
REQ-008 Step rules in MOVE_RIGHT:
- If Aliens_Col+40*jmax+30+StepX > ScreenWidth-1: Aliens_Row += StepY, Aliens_Col is unchanged, next state is MOVE_LEFT.
- Otherwise: Aliens_Col += StepX.
REQ-009 Step rules in MOVE_LEFT:
- If Aliens_Col+40*jmin < StepX: Aliens_Row += StepY, Aliens_Col is unchanged, next state is MOVE_RIGHT.
- Otherwise: Aliens_Col -= StepX.
REQ-010 A drop SHALL never move horizontally in the same step. Aliens_Col SHALL never wrap below 0 or exceed 639.
REQ-011 Landing check:
- Evaluated every cycle: Aliens_Row+30*imax+20 >= LandRow with Aliens_Grid nonzero.
- When true, Aliens_Landed is set, state becomes HALTED, and the counter clears.
REQ-012 If Aliens_Defeated = 1 or Aliens_Grid = 0, state SHALL become HALTED on the next edge. Landing SHALL NOT be flagged in that case.
REQ-013 HALTED behaviour:
- Positions, Direction and Aliens_Landed are frozen.
- Step_Tick = 0.
- Only Reset leaves HALTED.
REQ-014 Direction SHALL be 1 in MOVE_RIGHT and 0 in MOVE_LEFT. In HALTED it retains its last value.
REQ-015 Grid changes in the same cycle as a step SHALL use the Aliens_Grid value sampled in that cycle, with no extra latency.
REQ-016 When Enable = 0, the counter and all outputs SHALL hold, and Step_Tick = 0.
REQ-017 All arithmetic SHALL be evaluated at 11 bits or wider to avoid overflow before comparison.

Reset
REQ-018 On Reset = 1 at a clock edge:
- Aliens_Row = StartRow (40), Aliens_Col = StartCol (20).
- Direction = 1, state = MOVE_RIGHT, counter = 0.
- Step_Tick = 0, Aliens_Landed = 0.
REQ-019 Reset SHALL take priority over all events, including a step or landing in the same cycle, and SHALL be honoured mid-operation.

Verification (BasePeriod=4, FastPeriod=2, other parameters at default)
REQ-020 Full grid, Enable=1 after reset:
- Step_Tick pulses every 4 cycles.
- Aliens_Col reads 30, 40, ... 240 after 22 steps.
- Step 23 gives Row 50, Col 240, Direction 0.
REQ-021 Continue from REQ-020:
- 24 left steps take Col to 0.
- The next step gives Row 60, Col 0, Direction 1.
REQ-022 Clear columns 8-9 (jmax=7) at reset: the first drop occurs after 30 right steps (Col 320).
REQ-023 Reduce the alive count to 10 mid-count: Step_Tick interval becomes 2 cycles, with no lost or doubled pulse beyond REQ-006.
REQ-024 Landing and halt:
- Force Row progression with imax=4 until Row=300: Aliens_Landed=1 and no further steps.
- Assert Reset: Row=40, Col=20, Aliens_Landed=0.
REQ-025 Pause and defeat:
- Enable=0 for 10 cycles: outputs unchanged.
- Assert Aliens_Defeated: HALTED next cycle, Aliens_Landed stays 0.
